// File: rtl/front_group_ctrl.sv
// Operand grouping front end: collects up to GROUP_N operands and presents them as one group.
// Optional macro FRONT_GROUP_TIMEOUT_EN flushes a partial group after TIMEOUT_CYC idle cycles.
module front_group_ctrl #(
    parameter int unsigned GROUP_N     = 4,
    parameter int unsigned CNT_W       = $clog2(GROUP_N + 1),
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_op_rdy,
    input  logic             I_op_last,
    input  logic             I_grp_ack,
    output logic             O_op_acc,
    output logic             O_grp_vld,
    output logic [CNT_W-1:0] O_grp_size,
    output logic             O_grp_last,
    output logic [CNT_W-1:0] O_fill_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_EMIT
    } state_t;

    localparam logic [CNT_W-1:0] GROUP_MAX = CNT_W'(GROUP_N);

    state_t           state;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             idle_expire;

    assign O_op_acc = (state != ST_EMIT) && !I_rst;
    assign accept   = I_op_rdy && O_op_acc;
    assign cnt_inc  = O_fill_cnt + CNT_W'(1);

`ifdef FRONT_GROUP_TIMEOUT_EN
    localparam int unsigned IDLE_W = 8;
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Consecutive FILL cycles without an accepted operand
    always_ff @(posedge I_clk) begin
        if (I_rst || accept || state != ST_FILL) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign idle_expire = (idle_cnt == IDLE_LIM);
`else
    assign idle_expire = 1'b0;
`endif

    // Grouping state machine with registered group outputs
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= ST_IDLE;
            O_grp_vld  <= 1'b0;
            O_grp_size <= '0;
            O_grp_last <= 1'b0;
            O_fill_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_FILL: begin
                    if (accept) begin
                        O_fill_cnt <= cnt_inc;
                        if (cnt_inc == GROUP_MAX || I_op_last) begin
                            state      <= ST_EMIT;
                            O_grp_vld  <= 1'b1;
                            O_grp_size <= cnt_inc;
                            O_grp_last <= I_op_last;
                        end else begin
                            state <= ST_FILL;
                        end
                    end else if (state == ST_FILL && I_op_last) begin
                        state      <= ST_EMIT;
                        O_grp_vld  <= 1'b1;
                        O_grp_size <= O_fill_cnt;
                        O_grp_last <= 1'b1;
                    end else if (state == ST_FILL && idle_expire) begin
                        state      <= ST_EMIT;
                        O_grp_vld  <= 1'b1;
                        O_grp_size <= O_fill_cnt;
                        O_grp_last <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (I_grp_ack) begin
                        state      <= ST_IDLE;
                        O_grp_vld  <= 1'b0;
                        O_grp_size <= '0;
                        O_grp_last <= 1'b0;
                        O_fill_cnt <= '0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    O_grp_vld  <= 1'b0;
                    O_grp_size <= '0;
                    O_grp_last <= 1'b0;
                    O_fill_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_front_group_ctrl.sv
// Randomized bench for front_group_ctrl against a stream-level grouping model.
module tb_front_group_ctrl;

    localparam int unsigned GROUP_N     = 4;
    localparam int unsigned CNT_W       = $clog2(GROUP_N + 1);
    localparam int unsigned TIMEOUT_CYC = 16;

    logic             I_clk = 1'b0;
    logic             I_rst;
    logic             I_op_rdy;
    logic             I_op_last;
    logic             I_grp_ack;
    logic             O_op_acc;
    logic             O_grp_vld;
    logic [CNT_W-1:0] O_grp_size;
    logic             O_grp_last;
    logic [CNT_W-1:0] O_fill_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: operands collected so far, and the group currently presented (if any)
    int m_cnt   = 0;
    bit m_emit  = 1'b0;
    int m_size  = 0;
    bit m_last  = 1'b0;
    int m_idle  = 0;
    int m_groups = 0;

    front_group_ctrl #(
        .GROUP_N    (GROUP_N),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .I_op_rdy  (I_op_rdy),
        .I_op_last (I_op_last),
        .I_grp_ack (I_grp_ack),
        .O_op_acc  (O_op_acc),
        .O_grp_vld (O_grp_vld),
        .O_grp_size(O_grp_size),
        .O_grp_last(O_grp_last),
        .O_fill_cnt(O_fill_cnt)
    );

    always #5 I_clk = ~I_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic present(input int size, input bit last);
        m_emit = 1'b1;
        m_size = size;
        m_last = last;
        m_idle = 0;
        m_groups++;
    endtask

    // One clock cycle: drive inputs, check acceptance, advance model, check registered outputs
    task automatic step(input bit rdy, input bit last, input bit ack, input bit rst);
        I_op_rdy  = rdy;
        I_op_last = last;
        I_grp_ack = ack;
        I_rst     = rst;
        #1;
        check_eq("op_acc", O_op_acc, (!m_emit && !rst) ? 1 : 0);
        @(posedge I_clk);
        #1;
        if (rst) begin
            m_cnt  = 0;
            m_emit = 1'b0;
            m_size = 0;
            m_last = 1'b0;
            m_idle = 0;
        end else if (m_emit) begin
            if (ack) begin
                m_emit = 1'b0;
                m_cnt  = 0;
            end
        end else if (rdy) begin
            m_cnt++;
            m_idle = 0;
            if (m_cnt == GROUP_N || last) present(m_cnt, last);
        end else if (m_cnt > 0 && last) begin
            present(m_cnt, 1'b1);
        end else if (m_cnt > 0) begin
`ifdef FRONT_GROUP_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT_CYC) present(m_cnt, 1'b0);
`endif
        end
        check_eq("grp_vld", O_grp_vld, m_emit ? 1 : 0);
        check_eq("fill_cnt", O_fill_cnt, m_cnt);
        if (m_emit) begin
            check_eq("grp_size", O_grp_size, m_size);
            check_eq("grp_last", O_grp_last, m_last ? 1 : 0);
        end
        if (rst) begin
            check_eq("rst_size", O_grp_size, 0);
            check_eq("rst_last", O_grp_last, 0);
        end
    endtask

    initial begin
        int groups_before;
        I_rst = 1'b1; I_op_rdy = 1'b0; I_op_last = 1'b0; I_grp_ack = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);

        // Full group of four, then ack
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("full_grp_vld", O_grp_vld, 1);
        check_eq("full_grp_size", O_grp_size, 4);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Three operands, last on the third
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("last_grp_size", O_grp_size, 3);
        check_eq("last_grp_last", O_grp_last, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Two operands, gap, lone last; then lone last in IDLE
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("flush_size", O_grp_size, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        groups_before = m_groups;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_last_no_grp", O_grp_vld, 0);

        // Hold with upstream pushing and no ack
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("held_size", O_grp_size, 4);
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // Reset pulse mid-FILL discards the partial group
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_fill_cnt", O_fill_cnt, 0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("post_rst_size", O_grp_size, 4);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // One operand then a long idle stretch
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (100) step(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FRONT_GROUP_TIMEOUT_EN
        check_eq("timeout_grp", O_grp_vld, 1);
        check_eq("timeout_size", O_grp_size, 1);
        check_eq("timeout_last", O_grp_last, 0);
`else
        check_eq("no_timeout_grp", O_grp_vld, 0);
        check_eq("no_timeout_cnt", O_fill_cnt, 1);
`endif
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Random phases with different upstream densities
        for (int ph = 0; ph < 9; ph++) begin
            int p_rdy;
            case (ph % 3)
                0:       p_rdy = 90;
                1:       p_rdy = 50;
                default: p_rdy = 4;
            endcase
            for (int c = 0; c < 500; c++) begin
                step(($urandom % 100) < p_rdy,
                     ($urandom % 100) < 12,
                     ($urandom % 100) < 40,
                     ($urandom % 200) == 0);
            end
        end
        check_eq("groups_seen", (m_groups > groups_before + 100) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/front_group_ctrl.md
FRONT_GROUP_CTRL -- requirements
Module: front_group_ctrl

Interface
REQ-001 The block SHALL provide parameter GROUP_N, default 4, maximum operands per group (legal 2..16).
REQ-002 The block SHALL provide derived parameter CNT_W, default 3, equal to clog2(GROUP_N+1).
REQ-003 The block SHALL provide parameter TIMEOUT_CYC, default 16, idle cycles before a partial-group flush (legal 1..255, used only with REQ-027).
REQ-004 Port I_clk  input  1  sole clock; all logic is rising-edge.
REQ-005 Port I_rst  input  1  reset; synchronous, active-high.
REQ-006 Port I_op_rdy  input  1  upstream operand valid this cycle.
REQ-007 Port I_op_last  input  1  final operand of the stream; may be high with or without I_op_rdy.
REQ-008 Port I_grp_ack  input  1  downstream accepts the presented group.
REQ-009 Port O_op_acc  output  1  operand accepted; combinational, high when state is not EMIT and I_rst is low.
REQ-010 Port O_grp_vld  output  1  a group is presented; registered.
REQ-011 Port O_grp_size  output  CNT_W  operand count of the presented group (1..GROUP_N); registered.
REQ-012 Port O_grp_last  output  1  the presented group was closed by I_op_last; registered.
REQ-013 Port O_fill_cnt  output  CNT_W  operands currently collected; registered.

Function
REQ-014 An operand SHALL be accepted only on a cycle where I_op_rdy=1 and O_op_acc=1.
REQ-015 State machine SHALL have states IDLE (cnt=0), FILL (0<cnt<GROUP_N) and EMIT (group presented).
REQ-016 IDLE: an accepted operand SHALL set cnt=1 and go to FILL, or go to EMIT if I_op_last=1 in the same cycle or GROUP_N=1 is reached.
REQ-017 FILL: an accepted operand SHALL increment cnt; if the new cnt equals GROUP_N or I_op_last=1, the next state SHALL be EMIT.
REQ-018 FILL with I_op_rdy=0 and I_op_last=1 SHALL close the partial group (size=cnt, O_grp_last=1) and go to EMIT.
REQ-019 IDLE with I_op_rdy=0 and I_op_last=1 SHALL be ignored; no empty group is ever emitted.
REQ-020 Group latency SHALL be one cycle: O_grp_vld rises on the clock edge that accepts the completing operand.
REQ-021 In EMIT, O_grp_vld, O_grp_size and O_grp_last SHALL hold stable until a cycle with I_grp_ack=1.
REQ-022 I_grp_ack=1 in EMIT SHALL return to IDLE with cnt=0 and O_grp_vld=0 on the next edge; operands are not accepted in that ack cycle.
REQ-023 I_grp_ack outside EMIT SHALL have no effect.
REQ-024 O_grp_last SHALL be 0 for a group closed by reaching GROUP_N without I_op_last, and 1 when I_op_last coincided with or caused the close.

Reset
REQ-025 While I_rst=1, state SHALL be IDLE, cnt=0, O_grp_vld=0, O_grp_size=0, O_grp_last=0, O_fill_cnt=0 and O_op_acc=0.
REQ-026 Reset asserted mid-FILL or mid-EMIT SHALL discard the partial or presented group without emitting it; the first cycle after reset release SHALL behave as IDLE.

Configuration
REQ-027 With macro FRONT_GROUP_TIMEOUT_EN defined, FILL SHALL count consecutive cycles with no accepted operand (reset on each acceptance); at TIMEOUT_CYC it SHALL close the partial group with O_grp_last=0 and go to EMIT.
REQ-028 Without FRONT_GROUP_TIMEOUT_EN, no idle counter SHALL exist and a partial group SHALL wait indefinitely in FILL.

Verification
REQ-029 GROUP_N=4, I_op_rdy=1 for 4 cycles, I_grp_ack=1 -> O_grp_vld one cycle after the 4th operand, size=4, last=0; O_op_acc low during EMIT.
REQ-030 GROUP_N=4, 3 operands with I_op_last on the 3rd -> size=3, last=1; then IDLE.
REQ-031 2 operands, gap, then I_op_last alone with I_op_rdy=0 -> size=2, last=1; then I_op_last alone in IDLE -> no group.
REQ-032 Group held with I_grp_ack=0 for 5 cycles while I_op_rdy=1 -> outputs stable, no operand accepted; ack -> IDLE next edge.
REQ-033 I_rst pulsed one cycle during FILL with cnt=2 -> no group emitted, O_fill_cnt=0; next 4 operands produce size=4.
REQ-034 FRONT_GROUP_TIMEOUT_EN, TIMEOUT_CYC=16, 1 operand then idle -> group size=1, last=0 after 16 idle cycles; without the macro, no group after 100 cycles.
